// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//
// Two-stage pipelined RV32I immediate encoder. It scatters a 32-bit signed
// immediate into the I/S/B/J field positions of a base instruction word. It is
// the exact inverse of the core's immediate generator, using the same ImmSrc
// coding. Range and alignment errors are flagged, and flagged words are still
// delivered. Saturating counters tally clean and flagged deliveries.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   input word present
//   in_ready    out  1   encoder accepts input this cycle
//   in_base     in   32  base instruction; immediate field bits are overwritten
//   in_imm      in   32  signed immediate (byte offset for B/J)
//   in_imm_src  in   2   00=I, 01=S, 10=B, 11=J
//   out_valid   out  1   encoded word present
//   out_ready   in   1   downstream accepts
//   out_instr   out  32  encoded instruction
//   out_err     out  2   bit0 = range error, bit1 = misalignment error
//   cnt_clr     in   1   synchronous clear of both counters
//   ok_count    out  16  words delivered with out_err == 0, saturating
//   err_count   out  16  words delivered with out_err != 0, saturating
// -----------------------------------------------------------------------------
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [1:0]  in_imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_err,
    input  logic        cnt_clr,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        SrcI = 2'b00,
        SrcS = 2'b01,
        SrcB = 2'b10,
        SrcJ = 2'b11
    } imm_src_e;

    localparam logic [15:0] CntMax = 16'hFFFF;

    // Global pipeline advance: both stages move together or both hold.
    logic        w_adv;
    logic        w_out_fire;
    imm_src_e    w_in_src;
    logic [1:0]  w_in_err;
    logic [31:0] w_s1_pack;

    // Stage 1: captured inputs plus error flags.
    logic        r_s1_valid;
    logic [31:0] r_s1_base;
    logic [20:0] r_s1_imm;    // only imm[20:0] ever lands in a field
    imm_src_e    r_s1_src;
    logic [1:0]  r_s1_err;

    // Stage 2: packed word and flags, drives the outputs directly.
    logic        r_s2_valid;
    logic [31:0] r_s2_instr;
    logic [1:0]  r_s2_err;

    logic [15:0] r_ok_count;
    logic [15:0] r_err_count;

    assign w_adv      = !r_s2_valid || out_ready;
    assign w_out_fire = r_s2_valid && out_ready;
    assign w_in_src   = imm_src_e'(in_imm_src);

    assign in_ready  = w_adv;
    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign ok_count  = r_ok_count;
    assign err_count = r_err_count;

    // An immediate fits when every bit from the field's sign position upward
    // equals the sign, i.e. the slice is all-ones or all-zeros.
    always_comb begin
        w_in_err = 2'b00;
        unique case (w_in_src)
            SrcI, SrcS: begin
                w_in_err[0] = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            SrcB: begin
                w_in_err[0] = !((&in_imm[31:12]) || !(|in_imm[31:12]));
                w_in_err[1] = in_imm[0];
            end
            SrcJ: begin
                w_in_err[0] = !((&in_imm[31:20]) || !(|in_imm[31:20]));
                w_in_err[1] = in_imm[0];
            end
            default: begin
                w_in_err = 2'b00;
            end
        endcase
    end

    // Field scatter; bits outside the immediate fields pass through from base.
    always_comb begin
        w_s1_pack = r_s1_base;
        unique case (r_s1_src)
            SrcI: begin
                w_s1_pack[31:20] = r_s1_imm[11:0];
            end
            SrcS: begin
                w_s1_pack[31:25] = r_s1_imm[11:5];
                w_s1_pack[11:7]  = r_s1_imm[4:0];
            end
            SrcB: begin
                w_s1_pack[31]    = r_s1_imm[12];
                w_s1_pack[30:25] = r_s1_imm[10:5];
                w_s1_pack[11:8]  = r_s1_imm[4:1];
                w_s1_pack[7]     = r_s1_imm[11];
            end
            SrcJ: begin
                w_s1_pack[31]    = r_s1_imm[20];
                w_s1_pack[30:21] = r_s1_imm[10:1];
                w_s1_pack[20]    = r_s1_imm[11];
                w_s1_pack[19:12] = r_s1_imm[19:12];
            end
            default: begin
                w_s1_pack = r_s1_base;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_base  <= 32'd0;
            r_s1_imm   <= 21'd0;
            r_s1_src   <= SrcI;
            r_s1_err   <= 2'b00;
            r_s2_valid <= 1'b0;
            r_s2_instr <= 32'd0;
            r_s2_err   <= 2'b00;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_base <= in_base;
                r_s1_imm  <= in_imm[20:0];
                r_s1_src  <= w_in_src;
                r_s1_err  <= w_in_err;
            end
            r_s2_valid <= r_s1_valid;
            // Data only moves with a valid word so a bubble leaves the last
            // delivered word on the outputs.
            if (r_s1_valid) begin
                r_s2_instr <= w_s1_pack;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok_count  <= 16'd0;
            r_err_count <= 16'd0;
        end else if (cnt_clr) begin
            r_ok_count  <= 16'd0;
            r_err_count <= 16'd0;
        end else if (w_out_fire) begin
            if (r_s2_err == 2'b00) begin
                if (r_ok_count != CntMax) begin
                    r_ok_count <= r_ok_count + 16'd1;
                end
            end else begin
                if (r_err_count != CntMax) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder. Expected words come from a table-driven
// field-scatter model and signed-range arithmetic; a queue tracks words in
// flight so ordering, loss and duplication are all caught.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [1:0]  in_imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_err;
    logic        cnt_clr;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    int n_pass;
    int n_total;

    logic [31:0] q_instr[$];
    logic [1:0]  q_err[$];

    imm_encoder u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .cnt_clr    (cnt_clr),
        .ok_count   (ok_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each format is a list of (dest_lo, width, imm_lo) segments.
    function automatic logic [31:0] ref_pack(logic [31:0] base, logic [31:0] imm,
                                             logic [1:0] src);
        int dst [4];
        int wid [4];
        int sl [4];
        int n;
        logic [31:0] w;
        w = base;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            dst[k] = 0; wid[k] = 0; sl[k] = 0;
        end
        case (src)
            2'd0: begin
                n = 1; dst[0] = 20; wid[0] = 12; sl[0] = 0;
            end
            2'd1: begin
                n = 2;
                dst[0] = 25; wid[0] = 7; sl[0] = 5;
                dst[1] = 7;  wid[1] = 5; sl[1] = 0;
            end
            2'd2: begin
                n = 4;
                dst[0] = 31; wid[0] = 1; sl[0] = 12;
                dst[1] = 25; wid[1] = 6; sl[1] = 5;
                dst[2] = 8;  wid[2] = 4; sl[2] = 1;
                dst[3] = 7;  wid[3] = 1; sl[3] = 11;
            end
            default: begin
                n = 4;
                dst[0] = 31; wid[0] = 1;  sl[0] = 20;
                dst[1] = 21; wid[1] = 10; sl[1] = 1;
                dst[2] = 20; wid[2] = 1;  sl[2] = 11;
                dst[3] = 12; wid[3] = 8;  sl[3] = 12;
            end
        endcase
        for (int s = 0; s < n; s++) begin
            for (int b = 0; b < wid[s]; b++) begin
                w[dst[s] + b] = imm[sl[s] + b];
            end
        end
        return w;
    endfunction

    function automatic logic [1:0] ref_err(logic [31:0] imm, logic [1:0] src);
        int v;
        int lo;
        int hi;
        logic [1:0] e;
        v = int'(imm);
        case (src)
            2'd0, 2'd1: begin lo = -2048; hi = 2047; end
            2'd2:       begin lo = -4096; hi = 4095; end
            default:    begin lo = -(1 << 20); hi = (1 << 20) - 1; end
        endcase
        e = 2'b00;
        e[0] = (v < lo) || (v > hi);
        e[1] = (src >= 2'd2) && ((imm % 2) != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_imm();
        int edges [14];
        int v;
        edges = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                  1048574, 1048575, 1048576, -1048576, -1048577};
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 8191)) - 4096;
            1: v = int'($urandom);
            2: v = int'($urandom_range(0, 2097151)) - 1048576;
            default: v = edges[$urandom_range(0, 13)];
        endcase
        return v;
    endfunction

    task automatic drive_rand();
        in_base    = $urandom;
        in_imm     = rand_imm();
        in_imm_src = 2'($urandom_range(0, 3));
    endtask

    task automatic push_model();
        q_instr.push_back(ref_pack(in_base, in_imm, in_imm_src));
        q_err.push_back(ref_err(in_imm, in_imm_src));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_base = 32'd0; in_imm = 32'd0; in_imm_src = 2'd0;
        repeat (2) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_instr !== 32'd0) $display("FAIL reset_out_instr got %h want 0", out_instr);
        else n_pass++;
        n_total++;
        if (out_err !== 2'b00) $display("FAIL reset_out_err got %b want 00", out_err);
        else n_pass++;
        n_total++;
        if (ok_count !== 16'd0 || err_count !== 16'd0)
            $display("FAIL reset_counts got %h/%h want 0/0", ok_count, err_count);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] t_base [10];
        logic [31:0] t_imm [10];
        logic [1:0]  t_src [10];
        logic [31:0] t_exp [10];
        logic [1:0]  t_err [10];
        t_base = '{32'h13, 32'h2023, 32'h63, 32'h6F, 32'h6F, 32'h13, 32'h63, 32'h63,
                   32'h6F, 32'h2023};
        t_imm  = '{32'hFFFFFFFF, 32'd8, 32'hFFFFFFFC, 32'd2048, 32'hFFF00000, 32'd2048,
                   32'd3, 32'd4096, 32'h00100000, 32'hFFFFF800};
        t_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd3, 2'd1};
        t_exp  = '{32'hFFF00013, 32'h00002423, 32'hFE000EE3, 32'h0010006F, 32'h8000006F,
                   32'h80000013, 32'h00000163, 32'h80000063, 32'h8000006F, 32'h80002023};
        t_err  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            in_base = t_base[i]; in_imm = t_imm[i]; in_imm_src = t_src[i];
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b0)
                $display("FAIL dir%0d_latency_early out_valid got %b want 0", i, out_valid);
            else n_pass++;
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b1)
                $display("FAIL dir%0d_latency out_valid got %b want 1", i, out_valid);
            else n_pass++;
            n_total++;
            if (out_instr !== t_exp[i])
                $display("FAIL dir%0d_instr got %h want %h", i, out_instr, t_exp[i]);
            else n_pass++;
            n_total++;
            if (out_err !== t_err[i])
                $display("FAIL dir%0d_err got %b want %b", i, out_err, t_err[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n_ok;
        int n_bad;
        logic [31:0] e_i;
        logic [1:0]  e_e;
        n_ok = 0; n_bad = 0;
        q_instr.delete(); q_err.delete();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand();
            #1;
            if (out_valid && out_ready) begin
                n_total++;
                if (q_instr.size() == 0) begin
                    $display("FAIL rand_unexpected_word got %h want none", out_instr);
                end else begin
                    e_i = q_instr.pop_front(); e_e = q_err.pop_front();
                    if (out_instr !== e_i || out_err !== e_e)
                        $display("FAIL rand_word got %h/%b want %h/%b", out_instr, out_err,
                                 e_i, e_e);
                    else n_pass++;
                    if (e_e == 2'b00) n_ok++;
                    else n_bad++;
                end
            end
            if (in_valid && in_ready) push_model();
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                n_total++;
                if (q_instr.size() == 0) begin
                    $display("FAIL drain_unexpected_word got %h want none", out_instr);
                end else begin
                    e_i = q_instr.pop_front(); e_e = q_err.pop_front();
                    if (out_instr !== e_i || out_err !== e_e)
                        $display("FAIL drain_word got %h/%b want %h/%b", out_instr, out_err,
                                 e_i, e_e);
                    else n_pass++;
                    if (e_e == 2'b00) n_ok++;
                    else n_bad++;
                end
            end
        end
        @(negedge clk);
        #1;
        n_total++;
        if (q_instr.size() != 0)
            $display("FAIL rand_lost_words got %0d left want 0", q_instr.size());
        else n_pass++;
        n_total++;
        if (ok_count !== 16'(n_ok)) $display("FAIL rand_ok_count got %0d want %0d", ok_count, n_ok);
        else n_pass++;
        n_total++;
        if (err_count !== 16'(n_bad))
            $display("FAIL rand_err_count got %0d want %0d", err_count, n_bad);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nacc;
        int npop;
        int c;
        logic [31:0] e_i;
        logic [1:0]  e_e;
        nacc = 0; npop = 0; c = 0;
        q_instr.delete(); q_err.delete();
        while (npop < 3 && c < 20) begin
            @(negedge clk);
            in_valid  = (nacc < 3);
            out_ready = !(c >= 2 && c < 5);
            drive_rand();
            #1;
            if (!out_ready) begin
                n_total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1)
                    $display("FAIL bp_stall c%0d in_ready/out_valid got %b/%b want 0/1",
                             c, in_ready, out_valid);
                else n_pass++;
                n_total++;
                if (out_instr !== q_instr[0] || out_err !== q_err[0])
                    $display("FAIL bp_frozen c%0d got %h/%b want %h/%b", c, out_instr,
                             out_err, q_instr[0], q_err[0]);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_total++;
                e_i = q_instr.pop_front(); e_e = q_err.pop_front();
                if (out_instr !== e_i || out_err !== e_e)
                    $display("FAIL bp_order word%0d got %h/%b want %h/%b", npop, out_instr,
                             out_err, e_i, e_e);
                else n_pass++;
                npop++;
            end
            if (in_valid && in_ready) begin
                push_model();
                nacc++;
            end
            c++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_total++;
        if (npop != 3 || out_valid !== 1'b0)
            $display("FAIL bp_count got %0d words out_valid %b want 3 words out_valid 0",
                     npop, out_valid);
        else n_pass++;
    endtask

    task automatic test_counters();
        int fires;
        int cyc;
        fires = 0; cyc = 0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        in_base = 32'h13; in_imm = 32'd5; in_imm_src = 2'd0;
        while (fires < 70000 && cyc < 70100) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) fires++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++;
        if (ok_count !== 16'hFFFF)
            $display("FAIL cnt_saturate got %h want ffff (handshakes %0d)", ok_count, fires);
        else n_pass++;
        n_total++;
        if (err_count !== 16'd0) $display("FAIL cnt_err_zero got %h want 0", err_count);
        else n_pass++;
        @(negedge clk);
        cnt_clr = 1'b1; out_ready = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL cnt_clr_fire out_valid got %b want 1", out_valid);
        else n_pass++;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        n_total++;
        if (ok_count !== 16'd0) $display("FAIL cnt_clr_priority got %h want 0", ok_count);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (ok_count !== 16'd1) $display("FAIL cnt_after_clr got %h want 1", ok_count);
        else n_pass++;
    endtask

    task automatic test_midstream_reset();
        int npop;
        int nacc;
        logic [31:0] e_i;
        logic [1:0]  e_e;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        drive_rand();
        @(negedge clk);
        drive_rand();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || ok_count === 16'd0)
            $display("FAIL rst_precond out_valid/ok_count got %b/%h want 1/nonzero",
                     out_valid, ok_count);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_async out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (ok_count !== 16'd0 || err_count !== 16'd0)
            $display("FAIL rst_async_counts got %h/%h want 0/0", ok_count, err_count);
        else n_pass++;
        q_instr.delete(); q_err.delete();
        @(negedge clk);
        rst_n = 1'b1;
        npop = 0; nacc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = (nacc < 5); out_ready = 1'b1;
            drive_rand();
            #1;
            if (out_valid && out_ready) begin
                n_total++;
                if (q_instr.size() == 0) begin
                    $display("FAIL post_rst_stale_word got %h want none", out_instr);
                end else begin
                    e_i = q_instr.pop_front(); e_e = q_err.pop_front();
                    if (out_instr !== e_i || out_err !== e_e)
                        $display("FAIL post_rst_word got %h/%b want %h/%b", out_instr,
                                 out_err, e_i, e_e);
                    else n_pass++;
                    npop++;
                end
            end
            if (in_valid && in_ready) begin
                push_model();
                nacc++;
            end
        end
        n_total++;
        if (npop != 5) $display("FAIL post_rst_count got %0d want 5", npop);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_counters();
        test_midstream_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
